// File: rtl/uart_baud_gen_frac.sv
// rtl/uart_baud_gen_frac.sv - fractional-N UART baud generator with oversample tick, bit tick and baud clock
module uart_baud_gen_frac #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int RST_DIV_INT  = 54,
    parameter int RST_DIV_FRAC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    output logic              tick_os,
    output logic              baud_tick,
    output logic              clk_baud
);

    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_W:0]    cnt;
    logic [DIV_W:0]    d_eff;
    logic [DIV_W:0]    period;
    logic [DIV_W-1:0]  act_int;
    logic [DIV_W-1:0]  sh_int;
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] sh_frac;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;
    logic              carry;
    logic [OS_W-1:0]   os_cnt;
    logic              pending;
    logic              applied;
    logic              wrap;
    logic              os_last;
    logic              accept;

    // Divisors below 2 would give a zero or one cycle period; clamp them.
    assign d_eff   = (act_int < DIV_W'(2)) ? (DIV_W + 1)'(2) : {1'b0, act_int};
    assign period  = d_eff + {{DIV_W{1'b0}}, carry};
    assign wrap    = (cnt == period);
    assign os_last = (os_cnt == OS_LAST);
    assign sum     = {1'b0, acc} + {1'b0, act_frac};
    assign accept  = cfg_valid && cfg_ready;
    assign cfg_ready = ~(pending | applied);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            os_cnt    <= '0;
            tick_os   <= 1'b0;
            baud_tick <= 1'b0;
            clk_baud  <= 1'b0;
            pending   <= 1'b0;
            applied   <= 1'b0;
            sh_int    <= '0;
            sh_frac   <= '0;
            act_int   <= DIV_W'(RST_DIV_INT);
            act_frac  <= FRAC_W'(RST_DIV_FRAC);
        end else begin
            applied <= 1'b0;
            if (accept) begin
                sh_int  <= cfg_div_int;
                sh_frac <= cfg_div_frac;
                pending <= 1'b1;
            end
            if (!en) begin
                cnt       <= '0;
                acc       <= '0;
                carry     <= 1'b0;
                os_cnt    <= '0;
                tick_os   <= 1'b0;
                baud_tick <= 1'b0;
                clk_baud  <= 1'b0;
                if (pending) begin
                    act_int  <= sh_int;
                    act_frac <= sh_frac;
                    pending  <= 1'b0;
                    applied  <= 1'b1;
                end
            end else begin
                tick_os   <= wrap;
                baud_tick <= wrap && os_last;
                if (wrap) begin
                    // The tick edge is already the first cycle of the next period.
                    cnt   <= (DIV_W + 1)'(1);
                    acc   <= sum[FRAC_W-1:0];
                    carry <= sum[FRAC_W];
                    if (os_last) begin
                        os_cnt   <= '0;
                        clk_baud <= 1'b0;
                    end else begin
                        os_cnt <= os_cnt + OS_W'(1);
                        if (os_cnt == OS_HALF) begin
                            clk_baud <= 1'b1;
                        end
                    end
                    // Swap divisors only on a bit boundary so no bit is stretched mid-way.
                    if (os_last && pending) begin
                        act_int  <= sh_int;
                        act_frac <= sh_frac;
                        acc      <= '0;
                        carry    <= 1'b0;
                        pending  <= 1'b0;
                        applied  <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + (DIV_W + 1)'(1);
                end
            end
        end
    end

endmodule
